// File: rtl/seg7_hex_scan_if.sv
// Display-side bundle for seg7_hex_scan.
//   value/value_valid : 16-bit word and its capture strobe (upstream -> display)
//   dp_in             : per-digit decimal-point request, active-high
//   blank_lz          : leading-zero blanking enable
//   an_n/seg_n/dp_n   : board pins, all active-low (display -> board)
// master = producer of value/controls (and observer of pins), slave = the scanner.
interface seg7_hex_scan_if;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  modport master (output value, value_valid, dp_in, blank_lz,
                  input  an_n, seg_n, dp_n);
  modport slave  (input  value, value_valid, dp_in, blank_lz,
                  output an_n, seg_n, dp_n);
endinterface

// File: rtl/seg7_hex_scan.sv
// Four-digit multiplexed hex display driver for a common-anode 7-segment
// display. Each digit owns a slot of REFRESH_DIV clocks; the first
// BLANK_CYCLES of every slot keep all anodes off to suppress ghosting.
// The displayed word is reloaded only at the end of the last slot so a
// frame never mixes two values.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg7_hex_scan_if.slave (value in, an_n/seg_n/dp_n out)
// All pin outputs are registered: they reflect scan state one clock late.
module seg7_hex_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 64,
  parameter int DIGITS       = 4
) (
  input  logic clk,
  input  logic rst_n,
  seg7_hex_scan_if.slave bus
);

  generate
    if (DIGITS != 4) begin : g_bad_digits
      $error("seg7_hex_scan: DIGITS must be 4");
    end
    if (REFRESH_DIV < 2 || REFRESH_DIV <= BLANK_CYCLES) begin : g_bad_div
      $error("seg7_hex_scan: REFRESH_DIV must be >= 2 and > BLANK_CYCLES");
    end
  endgenerate

  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] BLANK_LIM = DW'(BLANK_CYCLES);

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   disp;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic [3:0]    nib;
  logic          lz;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] hex_dec(input logic [3:0] h);
    case (h)
      4'h0: hex_dec = 7'h40;  4'h1: hex_dec = 7'h79;
      4'h2: hex_dec = 7'h24;  4'h3: hex_dec = 7'h30;
      4'h4: hex_dec = 7'h19;  4'h5: hex_dec = 7'h12;
      4'h6: hex_dec = 7'h02;  4'h7: hex_dec = 7'h78;
      4'h8: hex_dec = 7'h00;  4'h9: hex_dec = 7'h10;
      4'hA: hex_dec = 7'h08;  4'hB: hex_dec = 7'h03;
      4'hC: hex_dec = 7'h46;  4'hD: hex_dec = 7'h21;
      4'hE: hex_dec = 7'h06;  default: hex_dec = 7'h0E;
    endcase
  endfunction

  always_comb begin
    nib = disp[{idx, 2'b00} +: 4];
    // A digit is a leading zero when it and every more-significant nibble
    // are zero; the rightmost digit always shows so 0 renders as "0".
    case (idx)
      2'd3:    lz = (disp[15:12] == 4'h0);
      2'd2:    lz = (disp[15:8]  == 8'h00);
      2'd1:    lz = (disp[15:4]  == 12'h000);
      default: lz = 1'b0;
    endcase
    seg_nxt = (bus.blank_lz && lz) ? 7'h7F : hex_dec(nib);
    an_nxt  = (div >= BLANK_LIM) ? ~(4'b0001 << idx) : 4'hF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      idx    <= 2'd0;
      shadow <= 16'h0000;
      disp   <= 16'h0000;
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      if (bus.value_valid) shadow <= bus.value;
      if (div == DIV_LAST) begin
        div <= '0;
        idx <= idx + 2'd1;
        // Frame boundary: a strobe on this very edge bypasses the shadow.
        if (idx == 2'd3) disp <= bus.value_valid ? bus.value : shadow;
      end else begin
        div <= div + 1'b1;
      end
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      dp_q  <= ~bus.dp_in[idx];
    end
  end

  assign bus.an_n  = an_q;
  assign bus.seg_n = seg_q;
  assign bus.dp_n  = dp_q;

endmodule

// File: tb/tb_seg7_hex_scan.sv
module tb_seg7_hex_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ecnt;
  slot_t sb[$];

  seg7_hex_scan_if bus();

  seg7_hex_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; between edges it is the index of the next edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Return at the negedge just before edge e (inputs set now are sampled at e;
  // outputs seen now reflect edge e-1).
  task automatic at_edge(input int e);
    while (ecnt < e) @(negedge clk);
  endtask

  task automatic push_frame(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dpm);
    sb.push_back('{an: 4'hE, seg: s0, dp: ~dpm[0]});
    sb.push_back('{an: 4'hD, seg: s1, dp: ~dpm[1]});
    sb.push_back('{an: 4'hB, seg: s2, dp: ~dpm[2]});
    sb.push_back('{an: 4'h7, seg: s3, dp: ~dpm[3]});
  endtask

  // Monitor: a lit slot begins when an_n leaves 4'hF; pop its expectation and
  // compare every lit cycle of the slot against it.
  initial begin
    logic [3:0] prev_an;
    slot_t      cur;
    bit         have;
    int         zeros;
    prev_an = 4'hF;
    have = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_an = 4'hF;
        have = 0;
      end else begin
        if (bus.an_n != 4'hF) begin
          zeros = 0;
          for (int i = 0; i < 4; i++) if (!bus.an_n[i]) zeros++;
          chk("one_anode", 16'(zeros), 16'd1);
          if (prev_an == 4'hF) begin
            have = (sb.size() > 0);
            if (have) cur = sb.pop_front();
          end
          if (have) begin
            chk("slot_an",  16'(bus.an_n),  16'(cur.an));
            chk("slot_seg", 16'(bus.seg_n), 16'(cur.seg));
            chk("slot_dp",  16'(bus.dp_n),  16'(cur.dp));
          end
        end
        prev_an = bus.an_n;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int blanks[4];
    int lit;
    bus.value = 16'h0;
    bus.value_valid = 1'b0;
    bus.dp_in = 4'h0;
    bus.blank_lz = 1'b0;

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_an",  16'(bus.an_n),  16'hF);
      chk("rst_seg", 16'(bus.seg_n), 16'h7F);
      chk("rst_dp",  16'(bus.dp_n),  16'h1);
    end
    rst_n = 1'b1;

    // Frame 0 still shows 0000 even though 0x1234 arrives mid-frame
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'h0);
    at_edge(1);  chk("rel_an_e0", 16'(bus.an_n), 16'hF);
    at_edge(2);  chk("rel_an_e1", 16'(bus.an_n), 16'hF);
    at_edge(3);  chk("rel_an_e2", 16'(bus.an_n), 16'hE);
                 chk("rel_seg_e2", 16'(bus.seg_n), 16'h40);
    at_edge(5);  bus.value = 16'h1234; bus.value_valid = 1'b1;
    at_edge(6);  bus.value_valid = 1'b0; bus.value = 16'hFFFF;

    // Frame 1: 1234, plus slot timing tally
    at_edge(32);
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'h0);
    lit = 0;
    for (int s = 0; s < 4; s++) blanks[s] = 0;
    for (int e = 32; e < 64; e++) begin
      at_edge(e + 1);
      if (bus.an_n == 4'hF) blanks[(e - 32) / 8]++;
      else lit++;
    end
    for (int s = 0; s < 4; s++) chk($sformatf("blank_slot%0d", s), 16'(blanks[s]), 16'd2);
    chk("lit_cycles", 16'(lit), 16'd24);

    // Frame 2 repeats 1234; strobe ABCD exactly on its wrap edge
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'h0);
    at_edge(95); bus.value = 16'hABCD; bus.value_valid = 1'b1;
    at_edge(96); bus.value_valid = 1'b0; bus.value = 16'h0;
    push_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'h0);

    // Leading-zero blanking: 0x00F0 then 0x0000
    at_edge(100); bus.blank_lz = 1'b1; bus.value = 16'h00F0; bus.value_valid = 1'b1;
    at_edge(101); bus.value_valid = 1'b0;
    at_edge(128); push_frame(7'h40, 7'h0E, 7'h7F, 7'h7F, 4'h0);
    at_edge(140); bus.value = 16'h0000; bus.value_valid = 1'b1;
    at_edge(141); bus.value_valid = 1'b0;
    at_edge(160); push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'h0);

    // Async reset while idx2 is lit (edge 211: idx2, div3)
    at_edge(192); bus.blank_lz = 1'b0;
    at_edge(212); chk("pre_rst_an", 16'(bus.an_n), 16'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an",  16'(bus.an_n),  16'hF);
    chk("async_seg", 16'(bus.seg_n), 16'h7F);
    chk("async_dp",  16'(bus.dp_n),  16'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // After recovery: shadow/disp cleared -> 0000; dp only on idx2
    bus.dp_in = 4'b0100;
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0100);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0100);
    at_edge(64);
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
